// File: rtl/rtc_bus_reader.sv
// rtc_bus_reader: read-cycle bus master for the RTC multiplexed AD bus.
// Each register costs one address phase (WR strobe) and one data phase
// (RD strobe); the address auto-increments across the burst and every
// byte read is announced with a one-cycle data_valid pulse.
module rtc_bus_reader #(
  parameter int unsigned T_SU  = 1,
  parameter int unsigned T_PW  = 10,
  parameter int unsigned T_H   = 3,
  parameter int unsigned T_REC = 10
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic [7:0] addr,
  input  logic [3:0] len,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       cs_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic       ad_n,
  output logic [7:0] data_out,
  output logic [3:0] data_idx,
  output logic       data_valid,
  output logic       busy,
  output logic       done
);

  typedef enum logic [3:0] {
    IDLE, A_SU, A_PW, A_H, A_REC, D_SU, D_PW, D_H, D_REC
  } state_t;

  // Phase counter terminal values: a timed state lasts exactly its count.
  localparam logic [3:0] SU_LAST  = 4'(T_SU - 1);
  localparam logic [3:0] PW_LAST  = 4'(T_PW - 1);
  localparam logic [3:0] H_LAST   = 4'(T_H - 1);
  localparam logic [3:0] REC_LAST = 4'(T_REC - 1);

  state_t     state, state_nx;
  logic [3:0] phase, phase_nx;
  logic [3:0] last_cnt;
  logic       phase_done;
  logic [7:0] cur_addr, cur_addr_nx;
  logic [3:0] remaining, remaining_nx;
  logic [3:0] index, index_nx;
  logic       capture, valid_nx, done_nx;
  logic       a_bus, d_bus;
  logic       cs_n_nx, wr_n_nx, rd_n_nx, ad_n_nx, ad_oe_nx, busy_nx;
  logic [7:0] ad_out_nx;

  // Select the terminal phase count for the state currently being timed.
  always_comb begin
    last_cnt = 4'd0;
    case (state)
      A_SU, D_SU:   last_cnt = SU_LAST;
      A_PW, D_PW:   last_cnt = PW_LAST;
      A_H, D_H:     last_cnt = H_LAST;
      A_REC, D_REC: last_cnt = REC_LAST;
      default:      last_cnt = 4'd0;
    endcase
    phase_done = (phase == last_cnt);
  end

  // Sequencing: next state, burst bookkeeping and the pulses that follow.
  always_comb begin
    state_nx     = state;
    phase_nx     = phase + 4'd1;
    cur_addr_nx  = cur_addr;
    remaining_nx = remaining;
    index_nx     = index;
    capture      = 1'b0;
    valid_nx     = 1'b0;
    done_nx      = 1'b0;
    case (state)
      IDLE: begin
        phase_nx = 4'd0;
        if (start) begin
          if (len != 4'd0) begin
            cur_addr_nx  = addr;
            remaining_nx = len;
            index_nx     = 4'd0;
            state_nx     = A_SU;
          end else begin
            done_nx = 1'b1;
          end
        end
      end
      A_SU:  if (phase_done) state_nx = A_PW;
      A_PW:  if (phase_done) state_nx = A_H;
      A_H:   if (phase_done) state_nx = A_REC;
      A_REC: if (phase_done) state_nx = D_SU;
      D_SU:  if (phase_done) state_nx = D_PW;
      D_PW: begin
        if (phase_done) begin
          state_nx = D_H;
          capture  = 1'b1;
          valid_nx = 1'b1;
        end
      end
      D_H:   if (phase_done) state_nx = D_REC;
      D_REC: begin
        if (phase_done) begin
          remaining_nx = remaining - 4'd1;
          if (remaining > 4'd1) begin
            cur_addr_nx = cur_addr + 8'd1;
            index_nx    = index + 4'd1;
            state_nx    = A_SU;
          end else begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    if (state_nx != state) phase_nx = 4'd0;
  end

  // Pin values are decoded from the upcoming state so they register cleanly.
  always_comb begin
    a_bus     = (state_nx == A_SU) || (state_nx == A_PW) || (state_nx == A_H);
    d_bus     = (state_nx == D_SU) || (state_nx == D_PW) || (state_nx == D_H);
    cs_n_nx   = !(a_bus || d_bus);
    wr_n_nx   = (state_nx != A_PW);
    rd_n_nx   = (state_nx != D_PW);
    ad_n_nx   = !(a_bus || (state_nx == A_REC));
    ad_oe_nx  = a_bus;
    ad_out_nx = a_bus ? cur_addr_nx : 8'h00;
    busy_nx   = (state_nx != IDLE);
  end

  // State, counters and every output pin are registered here.
  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= IDLE;
      phase      <= 4'd0;
      cur_addr   <= 8'h00;
      remaining  <= 4'd0;
      index      <= 4'd0;
      cs_n       <= 1'b1;
      wr_n       <= 1'b1;
      rd_n       <= 1'b1;
      ad_n       <= 1'b1;
      ad_oe      <= 1'b0;
      ad_out     <= 8'h00;
      busy       <= 1'b0;
      done       <= 1'b0;
      data_valid <= 1'b0;
      data_out   <= 8'h00;
      data_idx   <= 4'd0;
    end else begin
      state      <= state_nx;
      phase      <= phase_nx;
      cur_addr   <= cur_addr_nx;
      remaining  <= remaining_nx;
      index      <= index_nx;
      cs_n       <= cs_n_nx;
      wr_n       <= wr_n_nx;
      rd_n       <= rd_n_nx;
      ad_n       <= ad_n_nx;
      ad_oe      <= ad_oe_nx;
      ad_out     <= ad_out_nx;
      busy       <= busy_nx;
      done       <= done_nx;
      data_valid <= valid_nx;
      if (capture) begin
        data_out <= ad_in;
        data_idx <= index;
      end
    end
  end

endmodule

// File: tb/tb_rtc_bus_reader.sv
// Testbench for rtc_bus_reader: a default-timing instance and a short-timing
// instance, both compared against a cycle-position reference model of the bus.
module tb_rtc_bus_reader;

  typedef struct packed {
    logic cs_n;
    logic wr_n;
    logic rd_n;
    logic ad_n;
    logic ad_oe;
    logic busy;
  } pins_t;

  logic       clk = 1'b0;
  logic       clr;
  logic       start, s_start;
  logic [7:0] addr, s_addr;
  logic [3:0] len, s_len;
  logic [7:0] ad_in, s_ad_in;
  logic [7:0] ad_out, s_ad_out;
  logic       ad_oe, cs_n, wr_n, rd_n, ad_n;
  logic       s_ad_oe, s_cs_n, s_wr_n, s_rd_n, s_ad_n;
  logic [7:0] data_out, s_data_out;
  logic [3:0] data_idx, s_data_idx;
  logic       data_valid, busy, done;
  logic       s_data_valid, s_busy, s_done;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Observation records filled by observe() for the default-timing instance.
  pins_t      obs_pins[$];
  logic [7:0] obs_addr[$];
  logic [7:0] obs_data[$];
  logic [3:0] obs_idx[$];
  int         obs_valid_cyc[$];
  int         obs_done_cyc[$];
  int         obs_busy_cnt;
  int         obs_contention;

  always #5 clk = ~clk;

  rtc_bus_reader dut (
    .clk(clk), .clr(clr), .start(start), .addr(addr), .len(len),
    .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe), .cs_n(cs_n),
    .wr_n(wr_n), .rd_n(rd_n), .ad_n(ad_n), .data_out(data_out),
    .data_idx(data_idx), .data_valid(data_valid), .busy(busy), .done(done)
  );

  rtc_bus_reader #(.T_SU(2), .T_PW(1), .T_H(1), .T_REC(1)) dut_small (
    .clk(clk), .clr(clr), .start(s_start), .addr(s_addr), .len(s_len),
    .ad_in(s_ad_in), .ad_out(s_ad_out), .ad_oe(s_ad_oe), .cs_n(s_cs_n),
    .wr_n(s_wr_n), .rd_n(s_rd_n), .ad_n(s_ad_n), .data_out(s_data_out),
    .data_idx(s_data_idx), .data_valid(s_data_valid), .busy(s_busy), .done(s_done)
  );

  // Expected pins at cycle c after the first address-setup cycle of an n-byte
  // burst, derived only from the phase lengths.
  function automatic pins_t model_pins(int c, int n, int su, int pw, int h, int rec);
    int half, p, o;
    bit dph, strobe;
    pins_t r;
    half = su + pw + h + rec;
    p = 2 * half;
    r = 6'b111100;
    if (c >= 0 && c < n * p) begin
      o = c % p;
      dph = (o >= half);
      if (dph) o = o - half;
      strobe = (o >= su) && (o < su + pw);
      r.cs_n  = (o >= su + pw + h);
      r.wr_n  = !(strobe && !dph);
      r.rd_n  = !(strobe && dph);
      r.ad_n  = dph;
      r.ad_oe = !dph && (o < su + pw + h);
      r.busy  = 1'b1;
    end
    return r;
  endfunction

  // Request a burst on the default instance; the edge after this accepts it.
  task automatic begin_burst(input logic [7:0] a, input logic [3:0] l);
    start = 1'b1;
    addr = a;
    len = l;
  endtask

  // Run ncyc cycles, recording pins and events; the RTC model latches the
  // address seen under WR and returns it XOR key on the data phase.
  task automatic observe(input int ncyc, input int poke_a, input int poke_b, input logic [7:0] key);
    logic [7:0] bus_addr;
    logic prev_wr_n;
    obs_pins.delete(); obs_addr.delete(); obs_data.delete(); obs_idx.delete();
    obs_valid_cyc.delete(); obs_done_cyc.delete();
    obs_busy_cnt = 0;
    obs_contention = 0;
    bus_addr = 8'h00;
    prev_wr_n = wr_n;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      obs_pins.push_back({cs_n, wr_n, rd_n, ad_n, ad_oe, busy});
      if (!wr_n && prev_wr_n) obs_addr.push_back(ad_out);
      if (!wr_n) bus_addr = ad_out;
      if (data_valid) begin
        obs_valid_cyc.push_back(c);
        obs_data.push_back(data_out);
        obs_idx.push_back(data_idx);
      end
      if (done) obs_done_cyc.push_back(c);
      if (busy) obs_busy_cnt++;
      if ((ad_oe && !rd_n) || (!wr_n && !rd_n) || (ad_oe && ad_n)) obs_contention++;
      prev_wr_n = wr_n;
      ad_in = bus_addr ^ key;
      start = (c == poke_a) || (c == poke_b);
      if (start) begin
        addr = 8'h40;
        len = 4'd5;
      end
    end
  endtask

  task automatic test_reset();
    clr = 1'b1;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({cs_n, wr_n, rd_n, ad_n, ad_oe, busy, data_valid, done, ad_out, data_out, data_idx}
        !== {4'b1111, 4'b0000, 20'h0})
      $display("[TB] FAIL reset_values got %b %b %b %b %b %b %b %b %h %h %h required 1111 0000 00 00 0",
               cs_n, wr_n, rd_n, ad_n, ad_oe, busy, data_valid, done, ad_out, data_out, data_idx);
    else pass_cnt++;
    total_cnt++;
    if ({s_cs_n, s_busy, s_ad_oe} !== 3'b100)
      $display("[TB] FAIL reset_small got %b required 100", {s_cs_n, s_busy, s_ad_oe});
    else pass_cnt++;
    clr = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({cs_n, busy, done} !== 3'b100)
      $display("[TB] FAIL idle_after_reset got %b required 100", {cs_n, busy, done});
    else pass_cnt++;
  endtask

  task automatic test_bursts();
    logic [7:0] bases[6];
    logic [3:0] lens[6];
    logic [7:0] keys[6];
    logic [7:0] exp8;
    pins_t pe;
    int n;
    bases[0] = 8'h05; lens[0] = 4'd1; keys[0] = 8'hA2;
    bases[1] = 8'hFE; lens[1] = 4'd3; keys[1] = 8'h00;
    for (int i = 2; i < 6; i++) begin
      bases[i] = 8'($urandom);
      lens[i] = 4'($urandom_range(1, 4));
      keys[i] = 8'($urandom);
    end
    for (int i = 0; i < 6; i++) begin
      n = int'(lens[i]);
      begin_burst(bases[i], lens[i]);
      observe(n * 48 + 4, -1, -1, keys[i]);
      for (int c = 0; c < obs_pins.size(); c++) begin
        pe = model_pins(c, n, 1, 10, 3, 10);
        total_cnt++;
        if (obs_pins[c] !== pe)
          $display("[TB] FAIL burst%0d_pins c=%0d got %b required %b", i, c, obs_pins[c], pe);
        else pass_cnt++;
      end
      total_cnt++;
      if (obs_addr.size() != n || obs_valid_cyc.size() != n)
        $display("[TB] FAIL burst%0d_counts addr=%0d valid=%0d required %0d", i,
                 obs_addr.size(), obs_valid_cyc.size(), n);
      else begin
        pass_cnt++;
        for (int b = 0; b < n; b++) begin
          exp8 = bases[i] + 8'(b);
          total_cnt++;
          if (obs_addr[b] !== exp8)
            $display("[TB] FAIL burst%0d_addr b=%0d got %h required %h", i, b, obs_addr[b], exp8);
          else pass_cnt++;
          exp8 = exp8 ^ keys[i];
          total_cnt++;
          if (obs_data[b] !== exp8 || obs_idx[b] !== 4'(b) || obs_valid_cyc[b] != b * 48 + 35)
            $display("[TB] FAIL burst%0d_data b=%0d got %h/%0d@%0d required %h/%0d@%0d", i, b,
                     obs_data[b], obs_idx[b], obs_valid_cyc[b], exp8, b, b * 48 + 35);
          else pass_cnt++;
        end
        total_cnt++;
        if (data_out !== exp8)
          $display("[TB] FAIL burst%0d_hold got %h required %h", i, data_out, exp8);
        else pass_cnt++;
      end
      total_cnt++;
      if (obs_done_cyc.size() != 1 || obs_done_cyc[0] != n * 48 || obs_busy_cnt != n * 48)
        $display("[TB] FAIL burst%0d_done ndone=%0d busy=%0d required 1 at %0d busy %0d", i,
                 obs_done_cyc.size(), obs_busy_cnt, n * 48, n * 48);
      else pass_cnt++;
      total_cnt++;
      if (obs_contention != 0)
        $display("[TB] FAIL burst%0d_contention got %0d required 0", i, obs_contention);
      else pass_cnt++;
    end
  endtask

  task automatic test_zero_length();
    begin_burst(8'($urandom), 4'd0);
    observe(6, -1, -1, 8'h00);
    for (int c = 0; c < 6; c++) begin
      total_cnt++;
      if (obs_pins[c] !== 6'b111100)
        $display("[TB] FAIL zero_len_pins c=%0d got %b required 111100", c, obs_pins[c]);
      else pass_cnt++;
    end
    total_cnt++;
    if (obs_done_cyc.size() != 1 || obs_done_cyc[0] != 0 || obs_busy_cnt != 0)
      $display("[TB] FAIL zero_len_done ndone=%0d busy=%0d required 1 at 0 busy 0",
               obs_done_cyc.size(), obs_busy_cnt);
    else pass_cnt++;
  endtask

  task automatic test_start_ignored();
    logic [7:0] base;
    logic [7:0] exp8;
    pins_t pe;
    base = 8'($urandom);
    begin_burst(base, 4'd2);
    observe(100, 30, 96, 8'h00);
    for (int c = 0; c < 97; c++) begin
      pe = model_pins(c, 2, 1, 10, 3, 10);
      total_cnt++;
      if (obs_pins[c] !== pe)
        $display("[TB] FAIL ignored_pins c=%0d got %b required %b", c, obs_pins[c], pe);
      else pass_cnt++;
    end
    total_cnt++;
    if (obs_valid_cyc.size() != 2 || obs_data[0] !== base || obs_data[1] !== base + 8'd1)
      $display("[TB] FAIL ignored_data n=%0d required 2 bytes %h,%h", obs_valid_cyc.size(),
               base, base + 8'd1);
    else pass_cnt++;
    total_cnt++;
    if (obs_done_cyc.size() != 1 || obs_done_cyc[0] != 96)
      $display("[TB] FAIL ignored_done ndone=%0d required 1 at 96", obs_done_cyc.size());
    else pass_cnt++;
    total_cnt++;
    if ({obs_pins[97].cs_n, obs_pins[97].busy} !== 2'b01 || obs_addr.size() != 3 || obs_addr[2] !== 8'h40)
      $display("[TB] FAIL restart_in_done cs_n/busy=%b naddr=%0d required 01 with 3rd addr 40",
               {obs_pins[97].cs_n, obs_pins[97].busy}, obs_addr.size());
    else pass_cnt++;
    observe(240, -1, -1, 8'h00);
    total_cnt++;
    if (obs_valid_cyc.size() != 5)
      $display("[TB] FAIL restart_count got %0d required 5", obs_valid_cyc.size());
    else begin
      pass_cnt++;
      for (int b = 0; b < 5; b++) begin
        exp8 = 8'h40 + 8'(b);
        total_cnt++;
        if (obs_data[b] !== exp8 || obs_idx[b] !== 4'(b) || obs_valid_cyc[b] != b * 48 + 32)
          $display("[TB] FAIL restart_data b=%0d got %h/%0d@%0d required %h/%0d@%0d", b,
                   obs_data[b], obs_idx[b], obs_valid_cyc[b], exp8, b, b * 48 + 32);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (obs_done_cyc.size() != 1 || obs_done_cyc[0] != 237)
      $display("[TB] FAIL restart_done ndone=%0d required 1 at 237", obs_done_cyc.size());
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_burst();
    logic [7:0] base, key, exp8;
    base = 8'($urandom);
    key = 8'($urandom);
    begin_burst(base, 4'd2);
    observe(28, -1, -1, key);
    clr = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({cs_n, wr_n, rd_n, ad_n, ad_oe, busy, data_valid, done, ad_out, data_out, data_idx}
        !== {4'b1111, 4'b0000, 20'h0})
      $display("[TB] FAIL midreset_values got %b %b %b %b %b %b %b %b %h %h %h required 1111 0000 00 00 0",
               cs_n, wr_n, rd_n, ad_n, ad_oe, busy, data_valid, done, ad_out, data_out, data_idx);
    else pass_cnt++;
    clr = 1'b0;
    observe(60, -1, -1, key);
    total_cnt++;
    if (obs_valid_cyc.size() != 0 || obs_done_cyc.size() != 0 || obs_busy_cnt != 0)
      $display("[TB] FAIL midreset_quiet valid=%0d done=%0d busy=%0d required 0 0 0",
               obs_valid_cyc.size(), obs_done_cyc.size(), obs_busy_cnt);
    else pass_cnt++;
    base = 8'($urandom);
    begin_burst(base, 4'd1);
    observe(52, -1, -1, key);
    exp8 = base ^ key;
    total_cnt++;
    if (obs_valid_cyc.size() != 1 || obs_data[0] !== exp8 || obs_done_cyc.size() != 1 || obs_done_cyc[0] != 48)
      $display("[TB] FAIL midreset_recover nvalid=%0d ndone=%0d required 1 byte %h, done at 48",
               obs_valid_cyc.size(), obs_done_cyc.size(), exp8);
    else pass_cnt++;
  endtask

  task automatic test_small_params();
    logic [7:0] base, key, bus_a, exp8;
    int n, wr_low, nvalid, ndone, done_c;
    pins_t pg, pe;
    for (int rep = 0; rep < 3; rep++) begin
      base = 8'($urandom);
      key = 8'($urandom);
      n = $urandom_range(1, 4);
      s_addr = base;
      s_len = 4'(n);
      s_start = 1'b1;
      wr_low = 0; nvalid = 0; ndone = 0; done_c = -1;
      bus_a = 8'h00;
      for (int c = 0; c < n * 10 + 4; c++) begin
        @(negedge clk);
        s_start = 1'b0;
        pg = {s_cs_n, s_wr_n, s_rd_n, s_ad_n, s_ad_oe, s_busy};
        pe = model_pins(c, n, 2, 1, 1, 1);
        total_cnt++;
        if (pg !== pe)
          $display("[TB] FAIL small%0d_pins c=%0d got %b required %b", rep, c, pg, pe);
        else pass_cnt++;
        total_cnt++;
        if ((s_ad_oe && !s_rd_n) || (!s_wr_n && !s_rd_n) || (s_ad_oe && s_ad_n))
          $display("[TB] FAIL small%0d_contention c=%0d got oe=%b wr=%b rd=%b adn=%b required no overlap",
                   rep, c, s_ad_oe, s_wr_n, s_rd_n, s_ad_n);
        else pass_cnt++;
        if (!s_wr_n) begin
          wr_low++;
          bus_a = s_ad_out;
        end
        if (s_data_valid) begin
          exp8 = (base + 8'(nvalid)) ^ key;
          total_cnt++;
          if (s_data_out !== exp8 || s_data_idx !== 4'(nvalid) || c != nvalid * 10 + 8)
            $display("[TB] FAIL small%0d_data got %h/%0d@%0d required %h/%0d@%0d", rep,
                     s_data_out, s_data_idx, c, exp8, nvalid, nvalid * 10 + 8);
          else pass_cnt++;
          nvalid++;
        end
        if (s_done) begin
          ndone++;
          done_c = c;
        end
        s_ad_in = bus_a ^ key;
      end
      total_cnt++;
      if (wr_low != n || nvalid != n || ndone != 1 || done_c != n * 10)
        $display("[TB] FAIL small%0d_totals wr_low=%0d valid=%0d done=%0d@%0d required %0d %0d 1@%0d",
                 rep, wr_low, nvalid, ndone, done_c, n, n, n * 10);
      else pass_cnt++;
    end
  endtask

  // Bound the whole run so a stuck design still ends with a report.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  // Scenario sequence.
  initial begin
    clr = 1'b1;
    start = 1'b0; addr = 8'h00; len = 4'd0; ad_in = 8'h00;
    s_start = 1'b0; s_addr = 8'h00; s_len = 4'd0; s_ad_in = 8'h00;
    test_reset();
    test_bursts();
    test_zero_length();
    test_start_ignored();
    test_reset_mid_burst();
    test_small_params();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/rtc_bus_reader.md
# rtc_bus_reader

Bus master for read cycles on the real-time-clock chip's multiplexed address/data bus. It is the read-side counterpart of the existing write sequencer: given a base register address and a byte count, it runs one address phase (WR strobe) and one data phase (RD strobe) per register, auto-incrementing the address. Each byte is delivered to the display/capture logic through a one-cycle valid pulse. It sits between the top-level control FSM and the RTC pins, sharing the AD bus through `ad_oe`.

## Interface
- T_SU, 1: setup cycles, chip select active before the strobe (1..15)
- T_PW, 10: strobe low width in cycles, WR and RD (1..15)
- T_H, 3: hold cycles after the strobe rises, CS still active (1..15)
- T_REC, 10: recovery cycles with CS inactive after each phase (1..15)
- clk  in  1  system clock, all logic on rising edge
- clr  in  1  reset, synchronous, active-high
- start  in  1  request a burst; sampled only when `busy`=0
- addr  in  8  base register address, latched on accepted `start`
- len  in  4  number of registers to read (0..15)
- ad_in  in  8  AD bus input from the pad
- ad_out  out  8  AD bus drive value
- ad_oe  out  1  AD pad output enable (1 = drive `ad_out`)
- cs_n, wr_n, rd_n  out  1 each  RTC chip select, write strobe and read strobe, active-low
- ad_n  out  1  address/data select: 0 = address phase, 1 = data phase
- data_out  out  8  last byte read
- data_idx  out  4  index of `data_out` within the burst (0-based)
- data_valid  out  1  one-cycle pulse: `data_out`/`data_idx` are new
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse at burst end

## Operation
- All outputs are registered. No combinational path from inputs to pins.
- States: IDLE, A_SU, A_PW, A_H, A_REC, D_SU, D_PW, D_H, D_REC. A 4-bit phase counter times each state. A timed state lasts exactly its parameter count in cycles.
- IDLE: `cs_n`=`wr_n`=`rd_n`=`ad_n`=1, `ad_oe`=0, `busy`=0.
  - `start`=1 with `len`≠0: latch `addr`→cur_addr, `len`→remaining, clear the index, go to A_SU.
  - `start`=1 with `len`=0: no bus activity. Pulse `done` on the next cycle and stay in IDLE.
- A_SU/A_PW/A_H: `cs_n`=0, `ad_n`=0, `ad_oe`=1, `ad_out`=cur_addr. `wr_n`=0 only in A_PW.
- A_REC: `cs_n`=1, `ad_oe`=0, `ad_n`=0.
- D_SU/D_PW/D_H: `cs_n`=0, `ad_n`=1, `ad_oe`=0. `rd_n`=0 only in D_PW.
  - `ad_in` is captured into `data_out` on the edge that ends the last D_PW cycle.
  - `data_valid`=1 during the first D_H cycle, with `data_idx`=index.
- D_REC: `cs_n`=1.
  - On its last cycle, decrement remaining.
  - If remaining was >1: cur_addr+1 (8-bit wrap, 0xFF→0x00), index+1, go to A_SU.
  - Otherwise go to IDLE and assert `done`.
- `start` while `busy`=1 is ignored. `addr`/`len` changes during a burst have no effect.
- `data_out` holds its value until the next capture.

## Timing
- Accepted `start` at edge k: `busy`=1 and `cs_n`=0 from cycle k+1.
- Cycles per byte = 2·(T_SU+T_PW+T_H+T_REC). With defaults this is 48.
- With defaults, relative to the first A_SU cycle (cycle 0):
  - `wr_n` low cycles 1–10
  - `cs_n` high cycles 14–23
  - `rd_n` low cycles 25–34
  - `data_valid` at cycle 35
- Burst of N bytes: `done` is high in the single IDLE cycle that follows 48·N busy cycles. `busy`=0 in that same cycle.
- A `start` present in the `done` cycle is accepted.
- `ad_oe` is never 1 while `rd_n`=0, and is 0 in every D_* state.
- `wr_n` and `rd_n` are never both 0.
- Reset (`clr`=1 at an edge, any state): next cycle is IDLE, with:
  - `cs_n`=`wr_n`=`rd_n`=`ad_n`=1
  - `ad_oe`=0, `ad_out`=0
  - `data_out`=0, `data_idx`=0
  - `data_valid`=`done`=`busy`=0
  - A mid-burst reset produces no `done` and no `data_valid`.

## Test plan
- Single read: addr=0x05, len=1, `ad_in`=0xA7 throughout D_PW.
  - Expect `ad_out`=0x05 while `wr_n` is low.
  - Expect `data_valid` with `data_out`=0xA7, `data_idx`=0 at cycle 35.
  - Expect `done` 48 cycles after `busy` rises.
- Burst wrap: addr=0xFE, len=3, bus model returns the address value.
  - Expect addresses 0xFE, 0xFF, 0x00.
  - Expect data 0xFE, 0xFF, 0x00 at `data_idx` 0, 1, 2.
  - Expect exactly three `data_valid` pulses and one `done`, 144 busy cycles.
- Zero length: len=0, start.
  - Expect no strobe activity and `busy` stays 0.
  - Expect `done` one cycle later.
- Start ignored: second `start` (addr=0x40) mid-burst.
  - Expect the burst to proceed unchanged with no extra bytes.
  - Expect a `start` in the `done` cycle to begin a new burst next cycle.
- Reset mid D_PW: assert `clr` for one cycle.
  - Expect all outputs at reset values the next cycle.
  - Expect no `done` and no `data_valid`.
  - Expect a subsequent burst to complete normally.
- Parameters T_SU=2, T_PW=1, T_H=1, T_REC=1.
  - Expect `wr_n` low for exactly 1 cycle.
  - Expect 10 cycles per byte.
  - Expect the bus-contention invariants to hold every cycle.
